// File: rtl/uart_rx_sipo.sv
// rtl/uart_rx_sipo.sv - oversampled 8N1 UART receiver with serial-in/parallel-out shift register.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  armed_q, armed_d;
  logic                  rx_s;

  assign sync1_d = rx_in;
  assign sync2_d = sync1_q;
  assign rx_s    = sync2_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    armed_d    = armed_q;

    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          // A line that stayed low after a framing error must go high before re-arming.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end

        ST_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        ST_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        ST_STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
    end
  end

  assign rx_data_out = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb/tb_uart_rx_sipo.sv - directed bench for uart_rx_sipo, one tick per clk at OVERSAMPLE=16.
module tb_uart_rx_sipo;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       sample_tick;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_sipo #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .sample_tick(sample_tick),
    .rx_data_out(rx_data_out),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cnt++;
        got_q.push_back(rx_data_out);
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid && frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    sample_tick = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data_out), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    check("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("a5_data", 32'(rx_data_out), 32'hA5);
    check("a5_busy_after", 32'(busy), 32'h0);

    // Short low glitch is rejected at mid start bit
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_mid", 32'(busy), 32'h1);
    repeat (6) @(negedge clk);
    check("glitch_busy_end", 32'(busy), 32'h0);
    check("glitch_valid_cnt", 32'(valid_cnt), 32'd1);
    check("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // Bad stop bit followed by a held-low break
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("ferr_valid_cnt", 32'(valid_cnt), 32'd1);
    check("ferr_data_kept", 32'(rx_data_out), 32'hA5);
    check("break_busy", 32'(busy), 32'h0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("rearm_quiet_ferr", 32'(ferr_cnt), 32'd1);
    check("rearm_quiet_valid", 32'(valid_cnt), 32'd1);
    send_frame(8'h96, 1'b1);
    repeat (20) @(negedge clk);
    check("rearm_valid_cnt", 32'(valid_cnt), 32'd2);
    check("rearm_data", 32'(rx_data_out), 32'h96);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd4);
    check("b2b_first", 32'(got_q[2]), 32'h00);
    check("b2b_second", 32'(got_q[3]), 32'hFF);

    // Reset during data bit 3 of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    check("midframe_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx_in = 1'b1;
    #1;
    check("rst_async_data", 32'(rx_data_out), 32'h00);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_valid", 32'(rx_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_valid", 32'(valid_cnt), 32'd4);
    check("rst_no_ferr", 32'(ferr_cnt), 32'd1);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_valid_cnt", 32'(valid_cnt), 32'd5);
    check("post_rst_data", 32'(rx_data_out), 32'h5A);

    // Tick freeze in the middle of data bit 2 of 0xC3
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 96; i++) begin
      rx_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    check("freeze_busy", 32'(busy), 32'h1);
    check("freeze_valid_cnt", 32'(valid_cnt), 32'd5);
    check("freeze_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("freeze_data", 32'(rx_data_out), 32'h5A);
    sample_tick = 1'b1;
    repeat (12) @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (20) @(negedge clk);
    check("freeze_resume_valid", 32'(valid_cnt), 32'd6);
    check("freeze_resume_data", 32'(rx_data_out), 32'hC3);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning sample_tick pulses per bit period; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8, meaning payload bits per frame, LSB first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_in  input  1  asynchronous serial line; idle high.
REQ-006 sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-007 rx_data_out  output  DATA_BITS  last correctly framed byte.
REQ-008 rx_valid  output  1  one-clk pulse: rx_data_out just updated.
REQ-009 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer before use (rx_s); latency 2 clk.
REQ-012 Frame format SHALL be 8N1: 1 start (0), DATA_BITS data LSB first, 1 stop (1), no parity.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 All counters and FSM transitions SHALL advance only on clk edges where sample_tick=1; with sample_tick=0, state is frozen.
REQ-015 IDLE: if armed and rx_s=0 on a tick -> START, tick_cnt cleared to 0.
REQ-016 START: at tick OVERSAMPLE/2 (mid start bit), rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0; rx_s=1 -> IDLE (glitch rejected), no output activity.
REQ-017 DATA: every OVERSAMPLE ticks, sample rx_s into shift register MSB, shifting right; after DATA_BITS samples -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample rx_s; 1 -> rx_data_out <= shift register, rx_valid pulse; 0 -> frame_err pulse, rx_data_out unchanged, armed cleared; both -> IDLE.
REQ-019 rx_valid/frame_err SHALL assert in the clk cycle after the stop-bit sample edge, exactly one clk wide, never simultaneously.
REQ-020 armed SHALL clear on framing error and set when rx_s=1 observed in IDLE; line held low (break) SHALL NOT retrigger reception.
REQ-021 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.
REQ-022 tick_cnt width ceil(log2(OVERSAMPLE)); bit_cnt width ceil(log2(DATA_BITS+1)); no wrap beyond terminal counts.
REQ-023 busy SHALL be combinationally (state != IDLE).

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, tick_cnt 0, bit_cnt 0, shift register 0, rx_data_out 0, rx_valid 0, frame_err 0, synchronizer flops 1, armed 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_valid/frame_err; first full frame after release SHALL be received correctly.

Verification
REQ-026 OVERSAMPLE=16, tick every clk, send 0xA5 8N1 -> rx_data_out=0xA5, rx_valid high 1 clk, frame_err 0, busy low after.
REQ-027 rx_in low for 4 ticks then high -> no rx_valid/frame_err, FSM returns IDLE, busy falls before tick 9.
REQ-028 Send 0x3C with stop bit 0, then hold line low 40 ticks -> single frame_err pulse, rx_valid 0, rx_data_out still 0xA5, no further activity until line high and a new frame.
REQ-029 Frames 0x00 then 0xFF with zero idle gap -> two rx_valid pulses, outputs 0x00 then 0xFF.
REQ-030 rst pulse during DATA bit 3 of 0x81 -> outputs 0 at once, no pulse; subsequent 0x5A received as 0x5A.
REQ-031 sample_tick held 0 for 100 clk while rx_in toggles -> state, counters, outputs unchanged.
